three_dim_block_scanner: RTL and testbench
==========================================

THREE_DIM_BLOCK_SCANNER -- requirements
Module: three_dim_block_scanner

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 12, number of candidate blocks (legal range 2..64).
REQ-002 SHALL have parameter HALF_W, default 64, horizontal hit half-extent in pixels.
REQ-003 SHALL have parameter HALF_H, default 64, vertical hit half-extent in pixels.
REQ-004 SHALL have the following ports, one per line:
- clk_in  input  1  the single clock; all logic is on its rising edge
- rst_in  input  1  synchronous, active-low reset
- valid_in  input  1  pixel request valid
- ready_out  output  1  block can accept a request
- curr_time_in  input  18  timestamp passthrough
- x_in  input  11  pixel X
- y_in  input  10  pixel Y
- block_x_in  input  NUM_BLOCKS x 12  block centre X
- block_y_in  input  NUM_BLOCKS x 12  block centre Y
- block_z_in  input  NUM_BLOCKS x 14  block depth, unsigned; smaller is nearer
- block_color_in  input  NUM_BLOCKS x 1  colour
- block_direction_in  input  NUM_BLOCKS x 3  direction
- block_ID_in  input  NUM_BLOCKS x 8  ID
- block_visible_in  input  NUM_BLOCKS x 1  candidate enable
- valid_out  output  1  result valid
- ready_in  input  1  downstream ready
- curr_time_out  output  18  latched timestamp
- x_out  output  11  latched X
- y_out  output  10  latched Y
- block_x_out, block_y_out, block_z_out, block_color_out, block_direction_out, block_ID_out  outputs  12/12/14/1/3/8  winning block's fields
- block_index_out  output  clog2(NUM_BLOCKS)  winning index
- block_visible_out  output  1  1 = a hit was found

Function
REQ-005 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-006 ready_out SHALL be 1 exactly in IDLE; acceptance = valid_in && ready_out.
REQ-007 On acceptance SHALL snapshot curr_time_in, x_in, y_in and all block_* arrays; later input changes SHALL NOT affect the in-flight request.
REQ-008 SCAN SHALL test one candidate per cycle, index 0 to NUM_BLOCKS-1, then enter DONE.
REQ-009 Candidate i hits iff visible[i]=1 and |x - block_x[i]| <= HALF_W and |y - block_y[i]| <= HALF_H, differences computed as 13-bit signed, zero-extending x/y; no wrap-around.
REQ-010 Winner = hitting candidate with smallest block_z; on equal z, lowest index wins (strict-less replacement).
REQ-011 valid_out SHALL assert in DONE, exactly NUM_BLOCKS+1 cycles after the acceptance edge.
REQ-012 If no candidate hits, SHALL output block_visible_out=0, block_index_out=0, all block field outputs 0.
REQ-013 In DONE with ready_in=0, all outputs SHALL hold stable; with ready_in=1 SHALL return to IDLE next cycle (valid_out drops).
REQ-014 Throughput: at most one request per NUM_BLOCKS+2 cycles; no pipelining of requests.

Reset
REQ-015 When rst_in=0 at a clock edge: state IDLE, valid_out=0, ready_out=1 in the next cycle, every data output 0, any in-flight scan discarded with no result.
REQ-016 Reset SHALL take priority over acceptance and ready_in in the same cycle.

Verification
REQ-017 NUM_BLOCKS=12; pixel (100,100); block 3 at (120,90) z=500, block 7 at (80,110) z=200, both visible -> after 13 cycles valid_out=1, index 7, z=200, visible=1.
REQ-018 Blocks 2 and 5 both hit with z=300 -> index 2.
REQ-019 Pixel (0,0), all blocks at (500,500) or invisible -> visible_out=0, index 0, fields 0.
REQ-020 Hold ready_in=0 for 5 cycles in DONE while changing all inputs -> outputs unchanged, ready_out=0, then one handshake returns to IDLE.
REQ-021 Assert rst_in=0 at SCAN index 4 -> next cycle valid_out=0, ready_out=1; new request completes correctly.
REQ-022 Boundary: |dx|=64 hits, |dx|=65 misses; block_x=4095 vs x=2047 misses.

Source files
------------

// File: rtl/three_dim_block_scanner.sv
// rtl/three_dim_block_scanner.sv - depth-sorted hit search over a set of candidate blocks
// One request is snapshotted, scanned one candidate per cycle, and the nearest hit is presented.
module three_dim_block_scanner #(
  parameter int NUM_BLOCKS = 12,
  parameter int HALF_W     = 64,
  parameter int HALF_H     = 64
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [17:0]                   curr_time_in,
  input  logic [10:0]                   x_in,
  input  logic [9:0]                    y_in,
  input  logic [NUM_BLOCKS*12-1:0]      block_x_in,
  input  logic [NUM_BLOCKS*12-1:0]      block_y_in,
  input  logic [NUM_BLOCKS*14-1:0]      block_z_in,
  input  logic [NUM_BLOCKS-1:0]         block_color_in,
  input  logic [NUM_BLOCKS*3-1:0]       block_direction_in,
  input  logic [NUM_BLOCKS*8-1:0]       block_ID_in,
  input  logic [NUM_BLOCKS-1:0]         block_visible_in,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [17:0]                   curr_time_out,
  output logic [10:0]                   x_out,
  output logic [9:0]                    y_out,
  output logic [11:0]                   block_x_out,
  output logic [11:0]                   block_y_out,
  output logic [13:0]                   block_z_out,
  output logic                          block_color_out,
  output logic [2:0]                    block_direction_out,
  output logic [7:0]                    block_ID_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] block_index_out,
  output logic                          block_visible_out
);

  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int CW = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;

  logic [17:0]              t_q;
  logic [10:0]              x_q;
  logic [9:0]               y_q;
  logic [NUM_BLOCKS*12-1:0] bx_q;
  logic [NUM_BLOCKS*12-1:0] by_q;
  logic [NUM_BLOCKS*14-1:0] bz_q;
  logic [NUM_BLOCKS-1:0]    bc_q;
  logic [NUM_BLOCKS*3-1:0]  bd_q;
  logic [NUM_BLOCKS*8-1:0]  bid_q;
  logic [NUM_BLOCKS-1:0]    bv_q;

  logic [CW-1:0] cnt;
  logic          best_found;
  logic [IW-1:0] best_idx;
  logic [13:0]   best_z;

  logic [IW-1:0]      cidx;
  logic [11:0]        c_bx, c_by;
  logic [13:0]        c_bz;
  logic signed [12:0] dx, dy;
  logic [12:0]        adx, ady;
  logic               hit, better;

  // Differences are taken in 13-bit signed so a far-right block never wraps into range.
  always_comb begin
    cidx   = cnt[IW-1:0];
    c_bx   = bx_q[cidx*12 +: 12];
    c_by   = by_q[cidx*12 +: 12];
    c_bz   = bz_q[cidx*14 +: 14];
    dx     = $signed({2'b00, x_q}) - $signed({1'b0, c_bx});
    dy     = $signed({3'b000, y_q}) - $signed({1'b0, c_by});
    adx    = dx[12] ? 13'(-dx) : 13'(dx);
    ady    = dy[12] ? 13'(-dy) : 13'(dy);
    hit    = bv_q[cidx] && (adx <= 13'(HALF_W)) && (ady <= 13'(HALF_H));
    better = hit && (!best_found || (c_bz < best_z));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state               <= IDLE;
      ready_out           <= 1'b1;
      valid_out           <= 1'b0;
      cnt                 <= '0;
      best_found          <= 1'b0;
      best_idx            <= '0;
      best_z              <= '0;
      t_q                 <= '0;
      x_q                 <= '0;
      y_q                 <= '0;
      bx_q                <= '0;
      by_q                <= '0;
      bz_q                <= '0;
      bc_q                <= '0;
      bd_q                <= '0;
      bid_q               <= '0;
      bv_q                <= '0;
      curr_time_out       <= '0;
      x_out               <= '0;
      y_out               <= '0;
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= 1'b0;
      block_direction_out <= '0;
      block_ID_out        <= '0;
      block_index_out     <= '0;
      block_visible_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            t_q        <= curr_time_in;
            x_q        <= x_in;
            y_q        <= y_in;
            bx_q       <= block_x_in;
            by_q       <= block_y_in;
            bz_q       <= block_z_in;
            bc_q       <= block_color_in;
            bd_q       <= block_direction_in;
            bid_q      <= block_ID_in;
            bv_q       <= block_visible_in;
            cnt        <= '0;
            best_found <= 1'b0;
            best_idx   <= '0;
            best_z     <= '0;
            ready_out  <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (cnt != CW'(NUM_BLOCKS)) begin
            if (better) begin
              best_found <= 1'b1;
              best_idx   <= cidx;
              best_z     <= c_bz;
            end
            cnt <= cnt + 1'b1;
          end else begin
            // Final cycle publishes the winner; a miss leaves every block field at zero.
            curr_time_out       <= t_q;
            x_out               <= x_q;
            y_out               <= y_q;
            block_x_out         <= best_found ? bx_q[best_idx*12 +: 12] : '0;
            block_y_out         <= best_found ? by_q[best_idx*12 +: 12] : '0;
            block_z_out         <= best_found ? best_z : '0;
            block_color_out     <= best_found ? bc_q[best_idx] : 1'b0;
            block_direction_out <= best_found ? bd_q[best_idx*3 +: 3] : '0;
            block_ID_out        <= best_found ? bid_q[best_idx*8 +: 8] : '0;
            block_index_out     <= best_found ? best_idx : '0;
            block_visible_out   <= best_found;
            valid_out           <= 1'b1;
            state               <= DONE;
          end
        end
        DONE: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          ready_out <= 1'b1;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_three_dim_block_scanner.sv
// tb/tb_three_dim_block_scanner.sv - scoreboard bench for three_dim_block_scanner
module tb_three_dim_block_scanner;
  localparam int NB = 12;
  localparam int IW = $clog2(NB);

  typedef struct {
    logic          vis;
    logic [IW-1:0] idx;
    logic [11:0]   x;
    logic [11:0]   y;
    logic [13:0]   z;
    logic          c;
    logic [2:0]    d;
    logic [7:0]    id;
    logic [17:0]   t;
    logic [10:0]   px;
    logic [9:0]    py;
    int            cyc;
  } exp_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, valid_in, ready_out, valid_out, ready_in;
  logic [17:0] curr_time_in, curr_time_out;
  logic [10:0] x_in, x_out;
  logic [9:0]  y_in, y_out;
  logic [11:0] bx [NB];
  logic [11:0] by [NB];
  logic [13:0] bz [NB];
  logic        bc [NB];
  logic [2:0]  bd [NB];
  logic [7:0]  bid[NB];
  logic        bv [NB];
  logic [NB*12-1:0] bx_f, by_f;
  logic [NB*14-1:0] bz_f;
  logic [NB-1:0]    bc_f, bv_f;
  logic [NB*3-1:0]  bd_f;
  logic [NB*8-1:0]  bid_f;
  logic [11:0] block_x_out, block_y_out;
  logic [13:0] block_z_out;
  logic        block_color_out, block_visible_out;
  logic [2:0]  block_direction_out;
  logic [7:0]  block_ID_out;
  logic [IW-1:0] block_index_out;

  for (genvar g = 0; g < NB; g++) begin : g_pack
    assign bx_f[g*12 +: 12] = bx[g];
    assign by_f[g*12 +: 12] = by[g];
    assign bz_f[g*14 +: 14] = bz[g];
    assign bc_f[g]          = bc[g];
    assign bv_f[g]          = bv[g];
    assign bd_f[g*3 +: 3]   = bd[g];
    assign bid_f[g*8 +: 8]  = bid[g];
  end

  three_dim_block_scanner #(.NUM_BLOCKS(NB), .HALF_W(64), .HALF_H(64)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .curr_time_in(curr_time_in), .x_in(x_in), .y_in(y_in),
    .block_x_in(bx_f), .block_y_in(by_f), .block_z_in(bz_f), .block_color_in(bc_f),
    .block_direction_in(bd_f), .block_ID_in(bid_f), .block_visible_in(bv_f),
    .valid_out(valid_out), .ready_in(ready_in), .curr_time_out(curr_time_out),
    .x_out(x_out), .y_out(y_out), .block_x_out(block_x_out), .block_y_out(block_y_out),
    .block_z_out(block_z_out), .block_color_out(block_color_out),
    .block_direction_out(block_direction_out), .block_ID_out(block_ID_out),
    .block_index_out(block_index_out), .block_visible_out(block_visible_out)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic vprev = 1'b0;
  exp_t sb[$];

  always @(posedge clk_in) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({curr_time_out, x_out, y_out, block_x_out, block_y_out, block_z_out,
                 block_color_out, block_direction_out, block_ID_out, block_index_out,
                 block_visible_out, ready_out, valid_out});
  endfunction

  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in && valid_out && !vprev) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 128'(valid_out), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("latency",   128'(cyc),                 128'(e.cyc));
        chk("visible",   128'(block_visible_out),   128'(e.vis));
        chk("index",     128'(block_index_out),     128'(e.idx));
        chk("block_x",   128'(block_x_out),         128'(e.x));
        chk("block_y",   128'(block_y_out),         128'(e.y));
        chk("block_z",   128'(block_z_out),         128'(e.z));
        chk("color",     128'(block_color_out),     128'(e.c));
        chk("direction", 128'(block_direction_out), 128'(e.d));
        chk("id",        128'(block_ID_out),        128'(e.id));
        chk("time",      128'(curr_time_out),       128'(e.t));
        chk("x_out",     128'(x_out),               128'(e.px));
        chk("y_out",     128'(y_out),               128'(e.py));
      end
    end
    vprev = valid_out;
  end

  function automatic exp_t mk(input logic v, input int i, input logic [11:0] x, input logic [11:0] y,
                              input logic [13:0] z, input logic c, input logic [2:0] d, input logic [7:0] id);
    exp_t e;
    e.vis = v; e.idx = IW'(i); e.x = x; e.y = y; e.z = z; e.c = c; e.d = d; e.id = id;
    e.t = '0; e.px = '0; e.py = '0; e.cyc = 0;
    return e;
  endfunction

  task automatic clear_blocks();
    for (int i = 0; i < NB; i++) begin
      bx[i] = 12'd500; by[i] = 12'd500; bz[i] = 14'd0; bv[i] = 1'b0;
      bc[i] = i[0]; bd[i] = i[2:0]; bid[i] = 8'h10 + 8'(i);
    end
  endtask

  task automatic set_blk(input int i, input logic [11:0] x, input logic [11:0] y, input logic [13:0] z);
    bx[i] = x; by[i] = y; bz[i] = z; bv[i] = 1'b1;
  endtask

  task automatic scramble();
    for (int i = 0; i < NB; i++) begin
      bx[i] = 12'($urandom); by[i] = 12'($urandom); bz[i] = 14'($urandom);
      bc[i] = 1'($urandom); bd[i] = 3'($urandom); bid[i] = 8'($urandom); bv[i] = 1'($urandom);
    end
    x_in = 11'($urandom); y_in = 10'($urandom); curr_time_in = 18'($urandom);
  endtask

  task automatic run_req(input logic [10:0] px, input logic [9:0] py, input logic [17:0] t,
                         input exp_t e_in, input bit hold);
    exp_t e;
    int n;
    logic [127:0] snap;
    e = e_in;
    x_in = px; y_in = py; curr_time_in = t; ready_in = !hold; valid_in = 1'b1;
    chk("ready_before_accept", 128'(ready_out), 128'(1));
    @(negedge clk_in);
    valid_in = 1'b0;
    e.cyc = cyc + NB + 1; e.px = px; e.py = py; e.t = t;
    sb.push_back(e);
    n = 0;
    while (!valid_out && n < 40) begin
      scramble();
      @(negedge clk_in);
      n++;
    end
    if (!valid_out) begin
      chk("result_timeout", 128'(valid_out), 128'(1));
      return;
    end
    if (hold) begin
      snap = outs();
      for (int k = 0; k < 5; k++) begin
        scramble();
        valid_in = 1'b1;
        @(negedge clk_in);
        chk("hold_outputs", outs(), snap);
        chk("hold_ready", 128'(ready_out), 128'(0));
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
    end
    @(negedge clk_in);
    chk("release_valid", 128'(valid_out), 128'(0));
    chk("release_ready", 128'(ready_out), 128'(1));
  endtask

  initial begin
    rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    x_in = '0; y_in = '0; curr_time_in = '0;
    clear_blocks();
    repeat (3) @(negedge clk_in);
    chk("rst_ready",   128'(ready_out), 128'(1));
    chk("rst_valid",   128'(valid_out), 128'(0));
    chk("rst_outputs", outs(), 128'(2));
    rst_in = 1'b1;
    @(negedge clk_in);

    // nearer of two overlapping hits wins
    clear_blocks();
    set_blk(3, 12'd120, 12'd90, 14'd500);
    set_blk(7, 12'd80, 12'd110, 14'd200);
    run_req(11'd100, 10'd100, 18'h2_0001, mk(1, 7, 12'd80, 12'd110, 14'd200, 1, 3'd7, 8'h17), 0);

    // equal depth: lower index wins
    clear_blocks();
    set_blk(2, 12'd100, 12'd100, 14'd300);
    set_blk(5, 12'd100, 12'd100, 14'd300);
    run_req(11'd100, 10'd100, 18'h0_1234, mk(1, 2, 12'd100, 12'd100, 14'd300, 0, 3'd2, 8'h12), 0);

    // no hit anywhere
    clear_blocks();
    for (int i = 1; i < NB; i++) bv[i] = 1'b1;
    bx[0] = 12'd0; by[0] = 12'd0;
    run_req(11'd0, 10'd0, 18'h3_FFFF, mk(0, 0, 12'd0, 12'd0, 14'd0, 0, 3'd0, 8'h00), 0);

    // |dx|=64 hits, |dx|=65 and |dy|=65 miss
    clear_blocks();
    set_blk(1, 12'd1064, 12'd500, 14'd50);
    set_blk(4, 12'd935, 12'd500, 14'd10);
    set_blk(8, 12'd1000, 12'd435, 14'd5);
    run_req(11'd1000, 10'd500, 18'h0_0042, mk(1, 1, 12'd1064, 12'd500, 14'd50, 1, 3'd1, 8'h11), 0);

    // reset mid-scan at candidate 4 discards the request
    clear_blocks();
    set_blk(7, 12'd80, 12'd110, 14'd200);
    x_in = 11'd100; y_in = 10'd100; curr_time_in = 18'h1_1111; valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    chk("midrst_valid", 128'(valid_out), 128'(0));
    chk("midrst_ready", 128'(ready_out), 128'(1));
    chk("midrst_outputs", outs(), 128'(2));

    // far-right block must not wrap into range; diagonal edge hit
    clear_blocks();
    set_blk(0, 12'd4095, 12'd0, 14'd0);
    set_blk(6, 12'd1983, 12'd64, 14'd900);
    run_req(11'd2047, 10'd0, 18'h2_ABCD, mk(1, 6, 12'd1983, 12'd64, 14'd900, 0, 3'd6, 8'h16), 0);

    // backpressure hold
    clear_blocks();
    set_blk(2, 12'd100, 12'd100, 14'd300);
    set_blk(5, 12'd100, 12'd100, 14'd300);
    run_req(11'd100, 10'd100, 18'h0_5555, mk(1, 2, 12'd100, 12'd100, 14'd300, 0, 3'd2, 8'h12), 1);

    repeat (2) @(negedge clk_in);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
